// File: rtl/intr_ctrl.sv
// Interrupt controller: NR_SRC level/edge sources, fixed lowest-index priority,
// a single in-service claim/complete handshake and a small register bus.
module intr_ctrl #(
  parameter int NR_SRC = 8,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NR_SRC-1:0] src,
  output logic              irq,
  input  logic              bus_req,
  input  logic              bus_wen,
  input  logic [XLEN-1:0]   bus_addr,
  input  logic [XLEN-1:0]   bus_dat_i,
  output logic [XLEN-1:0]   bus_dat_o,
  output logic              bus_ready
);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  localparam logic [2:0] OFF_PENDING = 3'd0;
  localparam logic [2:0] OFF_ENABLE  = 3'd1;
  localparam logic [2:0] OFF_CLAIM   = 3'd2;
  localparam logic [2:0] OFF_MODE    = 3'd3;

  state_t            state;
  logic [4:0]        isid;
  logic [NR_SRC-1:0] en;
  logic [NR_SRC-1:0] mode;
  logic [NR_SRC-1:0] pend_e;
  logic [NR_SRC-1:0] src_q;

  logic [2:0]        off;
  logic              rd;
  logic              wr;
  logic              claim_fire;
  logic              cmpl_fire;
  logic [NR_SRC-1:0] rise;
  logic [NR_SRC-1:0] pend;
  logic [NR_SRC-1:0] claim_mask;
  logic [NR_SRC-1:0] mode_clr;
  logic [4:0]        best;
  logic [XLEN-1:0]   rd_data;
  logic              unused_bus_bits;

  // Returns 1 + lowest set index, or 0 when nothing is set.
  function automatic logic [4:0] lowest_id(input logic [NR_SRC-1:0] v);
    logic [4:0] id;
    id = 5'd0;
    for (int i = NR_SRC - 1; i >= 0; i--) begin
      if (v[i]) id = 5'(i + 1);
    end
    return id;
  endfunction

  assign bus_ready = 1'b1;
  assign unused_bus_bits = ^{bus_addr, bus_dat_i};

  assign off  = bus_addr[4:2];
  assign rd   = bus_req & ~bus_wen;
  assign wr   = bus_req & bus_wen;
  assign rise = src & ~src_q;

  // Edge sources show their latch, level sources show the live input.
  assign pend = (mode & pend_e) | (~mode & src);
  assign best = lowest_id(pend & en);

  assign claim_fire = rd && (off == OFF_CLAIM) && (state == IDLE) && (best != 5'd0);
  assign cmpl_fire  = wr && (off == OFF_CLAIM) && (state == SERVICE) &&
                      (bus_dat_i[4:0] == isid);

  always_comb begin
    claim_mask = '0;
    for (int i = 0; i < NR_SRC; i++) begin
      claim_mask[i] = claim_fire && (best == 5'(i + 1));
    end
  end

  assign mode_clr = (wr && (off == OFF_MODE)) ? bus_dat_i[NR_SRC-1:0] : '0;

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_PENDING: rd_data = XLEN'(pend);
      OFF_ENABLE:  rd_data = XLEN'(en);
      OFF_CLAIM:   rd_data = (state == IDLE) ? XLEN'(best) : '0;
      OFF_MODE:    rd_data = XLEN'(mode);
      default:     rd_data = '0;
    endcase
  end

  // Source capture and configuration registers; a fresh edge beats any clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en     <= '0;
      mode   <= '0;
      pend_e <= '0;
      src_q  <= '0;
    end else begin
      src_q  <= src;
      pend_e <= (pend_e & ~claim_mask & ~mode_clr) | (rise & mode);
      if (wr && (off == OFF_ENABLE)) en   <= bus_dat_i[NR_SRC-1:0];
      if (wr && (off == OFF_MODE))   mode <= bus_dat_i[NR_SRC-1:0];
    end
  end

  // Claim/complete FSM with registered irq and read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      isid      <= 5'd0;
      irq       <= 1'b0;
      bus_dat_o <= '0;
    end else begin
      irq       <= (state == IDLE) && (best != 5'd0);
      bus_dat_o <= rd ? rd_data : '0;
      case (state)
        IDLE: begin
          if (claim_fire) begin
            isid  <= best;
            state <= SERVICE;
          end
        end
        SERVICE: begin
          if (cmpl_fire) begin
            isid  <= 5'd0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: edge/level sources, claim/complete, reset and decode.
module tb_intr_ctrl;

  localparam int NR_SRC = 8;
  localparam int XLEN   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR_SRC-1:0] src;
  logic              irq;
  logic              bus_req;
  logic              bus_wen;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN-1:0]   bus_dat_i;
  logic [XLEN-1:0]   bus_dat_o;
  logic              bus_ready;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [XLEN-1:0] d;

  intr_ctrl #(.NR_SRC(NR_SRC), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .irq       (irq),
    .bus_req   (bus_req),
    .bus_wen   (bus_wen),
    .bus_addr  (bus_addr),
    .bus_dat_i (bus_dat_i),
    .bus_dat_o (bus_dat_o),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input logic [XLEN-1:0] addr, output logic [XLEN-1:0] data);
    bus_req  = 1'b1;
    bus_wen  = 1'b0;
    bus_addr = addr;
    tick();
    bus_req  = 1'b0;
    bus_addr = '0;
    data     = bus_dat_o;
  endtask

  task automatic bus_wr(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data);
    bus_req   = 1'b1;
    bus_wen   = 1'b1;
    bus_addr  = addr;
    bus_dat_i = data;
    tick();
    bus_req   = 1'b0;
    bus_wen   = 1'b0;
    bus_addr  = '0;
    bus_dat_i = '0;
  endtask

  initial begin
    rst = 1'b0; src = '0; bus_req = 1'b0; bus_wen = 1'b0;
    bus_addr = '0; bus_dat_i = '0;
    tick(); tick();
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_dat", bus_dat_o, 32'd0);
    chk("bus_ready", {31'd0, bus_ready}, 32'd1);
    rst = 1'b1;
    tick();

    // Timer pulse on src[0], edge mode
    bus_wr(32'h0C, 32'h0000_0025);
    bus_wr(32'h04, 32'h0000_00FF);
    src = 8'h01; tick(); src = 8'h00;
    chk("timer_irq_1cyc", {31'd0, irq}, 32'd0);
    tick();
    chk("timer_irq_2cyc", {31'd0, irq}, 32'd1);
    bus_rd(32'h08, d);
    chk("timer_claim", d, 32'd1);
    tick();
    chk("timer_irq_off", {31'd0, irq}, 32'd0);
    bus_rd(32'h00, d);
    chk("timer_pending", d, 32'd0);
    bus_wr(32'h08, 32'd1);
    bus_rd(32'h08, d);
    chk("timer_idle_claim", d, 32'd0);

    // Two edge sources, lowest index first
    src = 8'h24; tick(); src = 8'h00; tick();
    bus_rd(32'h08, d);
    chk("prio_claim3", d, 32'd3);
    bus_rd(32'h08, d);
    chk("prio_service_claim", d, 32'd0);
    bus_wr(32'h08, 32'd3);
    bus_rd(32'h08, d);
    chk("prio_claim6", d, 32'd6);
    bus_wr(32'h08, 32'd6);

    // Level source src[1]
    src = 8'h02; tick();
    bus_rd(32'h08, d);
    chk("level_claim2", d, 32'd2);
    bus_wr(32'h08, 32'd5);
    bus_rd(32'h08, d);
    chk("level_bad_cmpl", d, 32'd0);
    chk("level_irq_service", {31'd0, irq}, 32'd0);
    bus_wr(32'h08, 32'd2);
    chk("level_irq_at_cmpl", {31'd0, irq}, 32'd0);
    tick();
    chk("level_irq_reassert", {31'd0, irq}, 32'd1);
    src = 8'h00; tick();
    bus_rd(32'h00, d);
    chk("level_no_latch", d, 32'd0);

    // Rising edge in the same cycle as the claim of that source
    src = 8'h01; tick(); src = 8'h00; tick();
    src = 8'h01;
    bus_rd(32'h08, d);
    src = 8'h00;
    chk("race_claim1", d, 32'd1);
    bus_rd(32'h00, d);
    chk("race_pending", d, 32'd1);

    // Reset while in SERVICE
    rst = 1'b0; tick(); rst = 1'b1;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_dat", bus_dat_o, 32'd0);
    bus_rd(32'h00, d);
    chk("rst_pending", d, 32'd0);
    bus_rd(32'h04, d);
    chk("rst_enable", d, 32'd0);
    bus_rd(32'h0C, d);
    chk("rst_mode", d, 32'd0);
    bus_rd(32'h08, d);
    chk("rst_claim", d, 32'd0);
    chk("rst_irq_after", {31'd0, irq}, 32'd0);

    // Decode and width masking
    bus_wr(32'h04, 32'hFFFF_FFFF);
    bus_rd(32'h04, d);
    chk("enable_mask", d, 32'h0000_00FF);
    tick();
    chk("dat_idle_zero", bus_dat_o, 32'd0);
    bus_rd(32'h14, d);
    chk("unmapped_rd", d, 32'd0);
    bus_wr(32'h14, 32'd0);
    bus_rd(32'h04, d);
    chk("unmapped_wr", d, 32'h0000_00FF);

    // Disabled pending kept, exposed by enable, cleared by MODE write of 1
    bus_wr(32'h04, 32'd0);
    bus_wr(32'h0C, 32'h08);
    src = 8'h08; tick(); src = 8'h00; tick();
    bus_rd(32'h00, d);
    chk("masked_pending", d, 32'h08);
    bus_rd(32'h08, d);
    chk("masked_claim", d, 32'd0);
    chk("masked_irq", {31'd0, irq}, 32'd0);
    bus_wr(32'h04, 32'h08);
    tick();
    chk("enabled_irq", {31'd0, irq}, 32'd1);
    bus_wr(32'h0C, 32'h08);
    bus_rd(32'h00, d);
    chk("mode_clr_pending", d, 32'd0);
    tick();
    chk("mode_clr_irq", {31'd0, irq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
